// File: rtl/bsk_input_pkg.sv
// rtl/bsk_input_pkg.sv - shared types, defaults and helpers for the PRD/PRM input reader
package bsk_input_pkg;

  // Scan sequence of the shared input bus
  typedef enum logic [2:0] {
    SEL_PRD,
    SMP_PRD,
    GAP_PRD,
    SEL_PRM,
    SMP_PRM,
    GAP_PRM
  } state_t;

  localparam int unsigned SETUP_CYCLES_DEF = 1;
  localparam int unsigned DEBOUNCE_CNT_DEF = 4;

  // Bits needed to hold values 0..max_val (never less than one bit)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bsk_debounce16.sv
// rtl/bsk_debounce16.sv - whole-word debouncer for one 16-bit buffer bank
module bsk_debounce16
  import bsk_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample,
  input  logic [15:0] data,
  output logic [15:0] stable,
  output logic        loaded,
  output logic        changed
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [15:0]   last;
  logic          hit;

  // Run length of identical samples; cnt==0 means nothing sampled yet
  always_comb begin
    cnt_nxt = cnt;
    hit     = 1'b0;
    if (sample) begin
      if (cnt == '0 || data != last) begin
        cnt_nxt = CW'(1);
      end else if (cnt != CNT_MAX) begin
        cnt_nxt = cnt + CW'(1);
      end
      hit = (cnt_nxt == CNT_MAX);
    end
  end

  // Track the last sample and load the stable word once the run is long enough
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      last    <= '0;
      stable  <= '0;
      loaded  <= 1'b0;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (sample) begin
        cnt  <= cnt_nxt;
        last <= data;
      end
      if (hit) begin
        stable  <= data;
        loaded  <= 1'b1;
        changed <= (data != stable);
      end
    end
  end

endmodule

// File: rtl/bsk_input_reader.sv
// rtl/bsk_input_reader.sv - time-multiplexed PRD/PRM bus reader with debounced outputs
module bsk_input_reader
  import bsk_input_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = SETUP_CYCLES_DEF,
  parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] iData,
  output logic        oOePrd,
  output logic        oOePrm,
  output logic [15:0] oPrd,
  output logic [15:0] oPrm,
  output logic        oValid,
  output logic        oChange
);

  localparam int unsigned SW = cnt_width(SETUP_CYCLES);
  localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] setup_cnt;
  logic [SW-1:0] setup_nxt;
  logic          oe_prd_nxt;
  logic          oe_prm_nxt;
  logic          prd_loaded;
  logic          prm_loaded;
  logic          prd_changed;
  logic          prm_changed;

  // Next state, setup timing and next OE values; the GAP states give bus turnaround
  always_comb begin
    state_nxt = state;
    setup_nxt = '0;
    case (state)
      SEL_PRD: begin
        if (setup_cnt == SETUP_LAST) state_nxt = SMP_PRD;
        else                         setup_nxt = setup_cnt + SW'(1);
      end
      SMP_PRD: state_nxt = GAP_PRD;
      GAP_PRD: state_nxt = SEL_PRM;
      SEL_PRM: begin
        if (setup_cnt == SETUP_LAST) state_nxt = SMP_PRM;
        else                         setup_nxt = setup_cnt + SW'(1);
      end
      SMP_PRM: state_nxt = GAP_PRM;
      GAP_PRM: state_nxt = SEL_PRD;
      default: state_nxt = SEL_PRD;
    endcase
    oe_prd_nxt = (state_nxt == SEL_PRD) || (state_nxt == SMP_PRD);
    oe_prm_nxt = (state_nxt == SEL_PRM) || (state_nxt == SMP_PRM);
  end

  // State register with registered, glitch-free OE strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= GAP_PRM;
      setup_cnt <= '0;
      oOePrd    <= 1'b0;
      oOePrm    <= 1'b0;
    end else begin
      state     <= state_nxt;
      setup_cnt <= setup_nxt;
      oOePrd    <= oe_prd_nxt;
      oOePrm    <= oe_prm_nxt;
    end
  end

  bsk_debounce16 #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_prd (
    .clk     (clk),
    .rst     (rst),
    .sample  (state == SMP_PRD),
    .data    (iData),
    .stable  (oPrd),
    .loaded  (prd_loaded),
    .changed (prd_changed)
  );

  bsk_debounce16 #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_prm (
    .clk     (clk),
    .rst     (rst),
    .sample  (state == SMP_PRM),
    .data    (iData),
    .stable  (oPrm),
    .loaded  (prm_loaded),
    .changed (prm_changed)
  );

  assign oValid  = prd_loaded & prm_loaded;
  assign oChange = prd_changed | prm_changed;

endmodule

// File: tb/tb_bsk_input_reader.sv
// tb/tb_bsk_input_reader.sv - self-checking bench for bsk_input_reader
module tb_bsk_input_reader;

  localparam int S0 = 1, D0 = 4, S1 = 3, D1 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data0, data1;
  logic        oe_prd0, oe_prm0, valid0, chg0;
  logic        oe_prd1, oe_prm1, valid1, chg1;
  logic [15:0] prd0, prm0, prd1, prm1;

  always #5 clk = ~clk;

  bsk_input_reader #(.SETUP_CYCLES(S0), .DEBOUNCE_CNT(D0)) u0 (
    .clk(clk), .rst(rst), .iData(data0), .oOePrd(oe_prd0), .oOePrm(oe_prm0),
    .oPrd(prd0), .oPrm(prm0), .oValid(valid0), .oChange(chg0)
  );

  bsk_input_reader #(.SETUP_CYCLES(S1), .DEBOUNCE_CNT(D1)) u1 (
    .clk(clk), .rst(rst), .iData(data1), .oOePrd(oe_prd1), .oOePrm(oe_prm1),
    .oPrd(prd1), .oPrm(prm1), .oValid(valid1), .oChange(chg1)
  );

  int          checks = 0;
  int          failures = 0;
  int          chg_seen = 0;
  int          ecnt [2];
  int          nsmp [2][2];
  logic [15:0] hist [2][2][8];
  logic [15:0] m_stab [2][2];
  logic        m_done [2][2];
  logic        m_chg [2];
  logic [15:0] prd_val, prm_val;

  function automatic int setup_of(input int i);
    return (i == 0) ? S0 : S1;
  endfunction

  function automatic int db_of(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  // Expected OE from position within the scan period (bank 0 = PRD, 1 = PRM)
  function automatic logic m_oe(input int i, input int bank);
    int s, p, pos;
    s = setup_of(i);
    p = 2 * (s + 2);
    if (ecnt[i] < 1) return 1'b0;
    pos = (ecnt[i] - 1) % p;
    if (bank == 0) return (pos <= s);
    return (pos >= s + 2) && (pos <= 2 * s + 2);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      ecnt[i]  = 0;
      m_chg[i] = 1'b0;
      for (int b = 0; b < 2; b++) begin
        nsmp[i][b]   = 0;
        m_stab[i][b] = 16'h0000;
        m_done[i][b] = 1'b0;
      end
    end
  endtask

  // One rising edge of instance i; a bank loads once its last DB samples agree
  task automatic model_edge(input int i, input logic [15:0] d);
    int s, p, q, b, db;
    logic eq;
    s  = setup_of(i);
    db = db_of(i);
    p  = 2 * (s + 2);
    ecnt[i]++;
    m_chg[i] = 1'b0;
    if (ecnt[i] >= 2) begin
      q = (ecnt[i] - 2) % p;
      b = (q == s) ? 0 : (q == 2 * s + 2) ? 1 : -1;
      if (b >= 0) begin
        for (int k = 7; k > 0; k--) hist[i][b][k] = hist[i][b][k-1];
        hist[i][b][0] = d;
        if (nsmp[i][b] < 8) nsmp[i][b]++;
        if (nsmp[i][b] >= db) begin
          eq = 1'b1;
          for (int k = 0; k < db; k++) if (hist[i][b][k] != d) eq = 1'b0;
          if (eq) begin
            m_chg[i]     = (m_stab[i][b] != d);
            m_stab[i][b] = d;
            m_done[i][b] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk1 ("u0_oe_prd", oe_prd0, m_oe(0, 0));
    chk1 ("u0_oe_prm", oe_prm0, m_oe(0, 1));
    chk1 ("u0_oe_excl", oe_prd0 & oe_prm0, 1'b0);
    chk16("u0_prd", prd0, m_stab[0][0]);
    chk16("u0_prm", prm0, m_stab[0][1]);
    chk1 ("u0_valid", valid0, m_done[0][0] & m_done[0][1]);
    chk1 ("u0_change", chg0, m_chg[0]);
    chk1 ("u1_oe_prd", oe_prd1, m_oe(1, 0));
    chk1 ("u1_oe_prm", oe_prm1, m_oe(1, 1));
    chk1 ("u1_oe_excl", oe_prd1 & oe_prm1, 1'b0);
    chk16("u1_prd", prd1, m_stab[1][0]);
    chk16("u1_prm", prm1, m_stab[1][1]);
    chk1 ("u1_valid", valid1, m_done[1][0] & m_done[1][1]);
    chk1 ("u1_change", chg1, m_chg[1]);
  endtask

  // Buffer banks drive only while enabled; otherwise the bus floats to junk
  task automatic drive();
    data0 = m_oe(0, 0) ? prd_val : m_oe(0, 1) ? prm_val : 16'($urandom);
    data1 = 16'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) begin
      model_edge(0, data0);
      model_edge(1, data1);
    end
    #1;
    check_all();
    if (chg0) chg_seen++;
    drive();
  endtask

  // Assert reset between edges, check the immediate clear, release between edges
  task automatic reset_mid();
    #2 rst = 1'b1;
    model_clear();
    #1 check_all();
    repeat (2) step();
    #3 rst = 1'b0;
    drive();
  endtask

  task automatic run_timing(input string ph);
    chg_seen = 0;
    repeat (30) begin
      step();
      if (ecnt[0] == 20) chk16({ph, "_prd_e20"}, prd0, 16'h0000);
      if (ecnt[0] == 21) chk16({ph, "_prd_e21"}, prd0, 16'hAAAA);
      if (ecnt[0] == 21) chk1 ({ph, "_chg_e21"}, chg0, 1'b1);
      if (ecnt[0] == 22) chk1 ({ph, "_chg_e22"}, chg0, 1'b0);
      if (ecnt[0] == 23) chk1 ({ph, "_valid_e23"}, valid0, 1'b0);
      if (ecnt[0] == 24) chk16({ph, "_prm_e24"}, prm0, 16'h5555);
      if (ecnt[0] == 24) chk1 ({ph, "_valid_e24"}, valid0, 1'b1);
    end
    chk16({ph, "_chg_count"}, 16'(chg_seen), 16'd2);
  endtask

  function automatic logic [15:0] pick(input logic [15:0] base);
    int r;
    r = $urandom_range(0, 2);
    if (r == 0) return 16'($urandom);
    if (r == 1) return base ^ (16'd1 << $urandom_range(0, 15));
    return base;
  endfunction

  initial begin
    int guard;
    data0 = 16'h0000;
    data1 = 16'h0000;
    prd_val = 16'h0000;
    prm_val = 16'h0000;
    model_clear();
    #1 rst = 1'b1;
    #1 check_all();
    repeat (2) step();
    #3 rst = 1'b0;
    drive();

    // Constant zero bus: valid at edge 24, never a change pulse
    chg_seen = 0;
    repeat (30) begin
      step();
      if (ecnt[0] == 23) chk1("p1_valid_e23", valid0, 1'b0);
      if (ecnt[0] == 24) chk1("p1_valid_e24", valid0, 1'b1);
    end
    chk16("p1_chg_count", 16'(chg_seen), 16'd0);

    // Distinct words per bank from a fresh reset
    prd_val = 16'hAAAA;
    prm_val = 16'h5555;
    reset_mid();
    run_timing("p2");

    // Three-scan PRD glitch is filtered out
    prd_val = 16'hAAAB;
    drive();
    chg_seen = 0;
    repeat (18) step();
    prd_val = 16'hAAAA;
    drive();
    repeat (30) step();
    chk16("p3_prd_hold", prd0, 16'hAAAA);
    chk16("p3_chg_count", 16'(chg_seen), 16'd0);

    // Permanent PRM change gives one pulse
    prm_val = 16'h1234;
    drive();
    chg_seen = 0;
    repeat (36) step();
    chk16("p4_prm_new", prm0, 16'h1234);
    chk16("p4_chg_count", 16'(chg_seen), 16'd1);

    // Random words, single-bit flips and hold lengths against the model
    repeat (40) begin
      prd_val = pick(prd_val);
      prm_val = pick(prm_val);
      drive();
      repeat (6 * $urandom_range(1, 6)) step();
    end

    // Reset asserted mid SMP_PRM, then timing restarts from edge 1
    guard = 0;
    while (!(ecnt[0] >= 1 && (ecnt[0] - 1) % 6 == 4) && guard < 20) begin
      step();
      guard++;
    end
    chk1("p6_reach_smp_prm", guard < 20, 1'b1);
    prd_val = 16'hAAAA;
    prm_val = 16'h5555;
    reset_mid();
    run_timing("p6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
